ball_fsm: RTL and testbench



---
 rtl/ball_fsm.sv | 169 ++++++++++++++++
 tb/tb_ball_fsm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ball_fsm.sv
// Pong ball motion controller: serves from centre, moves once per frame,
// and reacts to one-shot bounce events from the collision logic.
module ball_fsm #(
   parameter int SCREEN_X     = 640,
   parameter int SCREEN_Y     = 480,
   parameter int BALL_SIZE    = 8,
   parameter int BASE_SPEED   = 2,
   parameter int MAX_SPEED    = 6,
   parameter int SERVE_FRAMES = 60
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [1:0] bounce,
   output logic [9:0] ball_pos_x,
   output logic [9:0] ball_pos_y,
   output logic [7:0] ball_size_x,
   output logic [7:0] ball_size_y,
   output logic       dir_x,
   output logic       dir_y,
   output logic [2:0] speed,
   output logic       serving
);

   localparam int CNT_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);

   localparam logic [9:0]        CX         = 10'(SCREEN_X / 2 - BALL_SIZE / 2);
   localparam logic [9:0]        CY         = 10'(SCREEN_Y / 2 - BALL_SIZE / 2);
   localparam logic signed [10:0] X_MAX     = 11'(SCREEN_X - BALL_SIZE);
   localparam logic signed [10:0] Y_MAX     = 11'(SCREEN_Y - BALL_SIZE);
   localparam logic [2:0]        BASE_SPD   = 3'(BASE_SPEED);
   localparam logic [2:0]        MAX_SPD    = 3'(MAX_SPEED);
   localparam logic [CNT_W-1:0]  SERVE_LOAD = CNT_W'(SERVE_FRAMES);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SERVE_WAIT = 2'd1,
      MOVING     = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [9:0]       x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic             dir_x_q, dir_x_d;
   logic             dir_y_q, dir_y_d;
   logic [2:0]       speed_q, speed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;
   logic             accepted;

   // One axis step in signed arithmetic so the low edge saturates instead of wrapping.
   function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic dir,
                                            input logic [2:0] spd,
                                            input logic signed [10:0] lim);
      logic signed [10:0] base;
      logic signed [10:0] delta;
      logic signed [10:0] nxt;
      base  = signed'({1'b0, pos});
      delta = signed'({8'b0, spd});
      nxt   = dir ? (base + delta) : (base - delta);
      if (nxt < 0)
         step_axis = 10'd0;
      else if (nxt > lim)
         step_axis = lim[9:0];
      else
         step_axis = nxt[9:0];
   endfunction

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         x_q     <= CX;
         y_q     <= CY;
         dir_x_q <= 1'b1;
         dir_y_q <= 1'b1;
         speed_q <= BASE_SPD;
         cnt_q   <= '0;
         armed_q <= 1'b1;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dir_x_q <= dir_x_d;
         dir_y_q <= dir_y_d;
         speed_q <= speed_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      dir_x_d  = dir_x_q;
      dir_y_d  = dir_y_q;
      speed_d  = speed_q;
      cnt_d    = cnt_q;
      accepted = armed_q && (bounce != 2'b00) && (state_q == MOVING);

      // A held bounce code acts once; re-arm only after the collision logic goes quiet.
      if (bounce == 2'b00)
         armed_d = 1'b1;
      else if (accepted)
         armed_d = 1'b0;
      else
         armed_d = armed_q;

      case (state_q)
         IDLE: begin
            x_d = CX;
            y_d = CY;
            if (start) begin
               state_d = SERVE_WAIT;
               cnt_d   = SERVE_LOAD;
            end
         end
         SERVE_WAIT: begin
            x_d = CX;
            y_d = CY;
            if (frame_tick) begin
               if (cnt_q <= CNT_ONE) begin
                  state_d = MOVING;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         MOVING: begin
            if (accepted && bounce == 2'b11) begin
               x_d     = CX;
               y_d     = CY;
               dir_x_d = ~dir_x_q;
               speed_d = BASE_SPD;
               state_d = SERVE_WAIT;
               cnt_d   = SERVE_LOAD;
            end else begin
               if (accepted && bounce == 2'b01) begin
                  dir_x_d = ~dir_x_q;
                  speed_d = (speed_q >= MAX_SPD) ? MAX_SPD : speed_q + 3'd1;
               end
               if (accepted && bounce == 2'b10)
                  dir_y_d = ~dir_y_q;
               // Motion uses the direction and speed updated by this cycle's bounce.
               if (frame_tick) begin
                  x_d = step_axis(x_q, dir_x_d, speed_d, X_MAX);
                  y_d = step_axis(y_q, dir_y_d, speed_d, Y_MAX);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ball_pos_x  = x_q;
      ball_pos_y  = y_q;
      ball_size_x = 8'(BALL_SIZE);
      ball_size_y = 8'(BALL_SIZE);
      dir_x       = dir_x_q;
      dir_y       = dir_y_q;
      speed       = speed_q;
      serving     = (state_q != MOVING);
   end

endmodule

// File: tb/tb_ball_fsm.sv
// Scoreboard bench for ball_fsm: a behavioural model predicts every registered
// output cycle; a monitor compares them after each rising edge.
module tb_ball_fsm;

   localparam int SX = 640;
   localparam int SY = 480;
   localparam int BS = 8;
   localparam int BASE = 2;
   localparam int MAXS = 6;
   localparam int SF = 3;
   localparam int CXM = SX / 2 - BS / 2;
   localparam int CYM = SY / 2 - BS / 2;

   localparam int M_IDLE  = 0;
   localparam int M_SERVE = 1;
   localparam int M_MOVE  = 2;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic [1:0] bounce = 2'b00;
   logic [9:0] ball_pos_x, ball_pos_y;
   logic [7:0] ball_size_x, ball_size_y;
   logic       dir_x, dir_y, serving;
   logic [2:0] speed;

   ball_fsm #(
      .SCREEN_X(SX), .SCREEN_Y(SY), .BALL_SIZE(BS),
      .BASE_SPEED(BASE), .MAX_SPEED(MAXS), .SERVE_FRAMES(SF)
   ) dut (
      .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .start(start),
      .bounce(bounce), .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
      .ball_size_x(ball_size_x), .ball_size_y(ball_size_y),
      .dir_x(dir_x), .dir_y(dir_y), .speed(speed), .serving(serving)
   );

   always #5 clock = ~clock;

   typedef struct {
      int x;
      int y;
      int dx;
      int dy;
      int spd;
      int serv;
      string tag;
   } expect_t;

   expect_t exp_q[$];
   int total = 0;
   int bad = 0;

   int m_mode, m_x, m_y, m_dx, m_dy, m_spd, m_cnt, m_armed;
   string cur_tag = "init";

   function automatic int clamp(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic model_step(input bit rst_n, input bit ft, input bit st, input int bn);
      bit acc;
      if (!rst_n) begin
         m_mode = M_IDLE; m_x = CXM; m_y = CYM; m_dx = 1; m_dy = 1;
         m_spd = BASE; m_cnt = 0; m_armed = 1;
         return;
      end
      acc = (m_armed == 1) && (bn != 0) && (m_mode == M_MOVE);
      if (bn == 0) m_armed = 1;
      else if (acc) m_armed = 0;
      if (m_mode == M_IDLE) begin
         if (st) begin m_mode = M_SERVE; m_cnt = SF; end
      end else if (m_mode == M_SERVE) begin
         if (ft) begin
            m_cnt = m_cnt - 1;
            if (m_cnt <= 0) begin m_mode = M_MOVE; m_cnt = 0; end
         end
      end else begin
         if (acc && bn == 3) begin
            m_x = CXM; m_y = CYM; m_dx = 1 - m_dx; m_spd = BASE;
            m_mode = M_SERVE; m_cnt = SF;
         end else begin
            if (acc && bn == 1) begin
               m_dx = 1 - m_dx;
               m_spd = (m_spd + 1 > MAXS) ? MAXS : m_spd + 1;
            end
            if (acc && bn == 2) m_dy = 1 - m_dy;
            if (ft) begin
               m_x = clamp(m_x + (m_dx == 1 ? m_spd : -m_spd), SX - BS);
               m_y = clamp(m_y + (m_dy == 1 ? m_spd : -m_spd), SY - BS);
            end
         end
      end
   endtask

   task automatic applyStimulus(input bit rst_n, input bit ft, input bit st, input int bn);
      expect_t e;
      @(negedge clock);
      reset_n    = rst_n;
      frame_tick = ft;
      start      = st;
      bounce     = 2'(bn);
      model_step(rst_n, ft, st, bn);
      e.x = m_x; e.y = m_y; e.dx = m_dx; e.dy = m_dy; e.spd = m_spd;
      e.serv = (m_mode != M_MOVE) ? 1 : 0;
      e.tag = cur_tag;
      exp_q.push_back(e);
   endtask

   task automatic checkOutput(input expect_t e);
      bit ok;
      total++;
      ok = (int'(ball_pos_x) == e.x) && (int'(ball_pos_y) == e.y) &&
           (int'(dir_x) == e.dx) && (int'(dir_y) == e.dy) &&
           (int'(speed) == e.spd) && (int'(serving) == e.serv) &&
           (int'(ball_size_x) == BS) && (int'(ball_size_y) == BS);
      if (!ok) begin
         bad++;
         $display("[TB] FAIL %s t=%0t got x=%0d y=%0d dx=%0d dy=%0d spd=%0d serv=%0d sz=%0d/%0d want x=%0d y=%0d dx=%0d dy=%0d spd=%0d serv=%0d sz=%0d",
                  e.tag, $time, ball_pos_x, ball_pos_y, dir_x, dir_y, speed, serving,
                  ball_size_x, ball_size_y, e.x, e.y, e.dx, e.dy, e.spd, e.serv, BS);
      end
   endtask

   // Monitor: every rising edge presents one registered output set.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
      end
   end

   initial begin
      int hold;
      int cur_bn;
      int r;
      int waited;

      cur_tag = "reset";
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 1, 1, 3);
      applyStimulus(1, 0, 0, 3);

      cur_tag = "serve";
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 0, 1, 0);
      for (int i = 0; i < SF; i++) begin
         applyStimulus(1, 1, 0, 2);
         applyStimulus(1, 0, 1, 0);
      end
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 0, 0, 0);

      cur_tag = "wall_hold";
      for (int i = 0; i < 5; i++) applyStimulus(1, i % 2, 0, 2);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 0, 2);
      applyStimulus(1, 0, 0, 0);

      cur_tag = "paddle";
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, 1, 0, 1);
         applyStimulus(1, 0, 0, 0);
      end

      cur_tag = "clamp";
      for (int i = 0; i < 120; i++) applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 0, 2);
      applyStimulus(1, 1, 0, 1);
      for (int i = 0; i < 120; i++) applyStimulus(1, 1, 0, 0);

      cur_tag = "score";
      applyStimulus(1, 1, 0, 3);
      for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 3);
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 3);
      applyStimulus(1, 0, 0, 0);

      cur_tag = "reset_serve";
      applyStimulus(1, 1, 0, 3);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 1, 0, 0);
      for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 0, 1, 0);
      for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0);

      cur_tag = "reset_move";
      applyStimulus(1, 1, 0, 1);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 1, 0, 2);
      for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0);

      cur_tag = "random";
      hold = 0;
      cur_bn = 0;
      for (int i = 0; i < 6000; i++) begin
         if (hold == 0) begin
            r = $urandom_range(0, 63);
            if (r < 40) cur_bn = 0;
            else if (r < 52) cur_bn = 1;
            else if (r < 63) cur_bn = 2;
            else cur_bn = 3;
            hold = $urandom_range(1, 6);
         end
         hold--;
         applyStimulus(($urandom_range(0, 700) != 0),
                       ($urandom_range(0, 2) == 0),
                       ($urandom_range(0, 30) == 0),
                       cur_bn);
      end

      applyStimulus(1, 0, 0, 0);
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(posedge clock);
         waited++;
      end
      #2;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
